// File: rtl/sequenciador_operandos_ula.sv
// Operand/opcode capture sequencer feeding the combinational ULA.
// Collects A, B and the opcode on successive confirm presses, runs the ULA for one cycle and latches its result and flags.
module sequenciador_operandos_ula #(
    parameter int WIDTH    = 8,
    parameter int OP_WIDTH = 3
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [WIDTH-1:0]    sw_dado,
    input  logic                btn_confirma,
    input  logic [WIDTH-1:0]    alu_resultado,
    input  logic [3:0]          alu_flags,
    output logic [WIDTH-1:0]    op_a,
    output logic [WIDTH-1:0]    op_b,
    output logic [OP_WIDTH-1:0] opcode,
    output logic                alu_valido,
    output logic [WIDTH-1:0]    resultado_reg,
    output logic [3:0]          flags_reg,
    output logic [2:0]          estado,
    output logic                pronto
);

    typedef enum logic [2:0] {
        CARGA_A  = 3'd0,
        CARGA_B  = 3'd1,
        CARGA_OP = 3'd2,
        EXECUTA  = 3'd3,
        EXIBE    = 3'd4
    } estado_t;

    // State is kept as a plain 3-bit vector so the illegal codes 5-7 are representable.
    logic [2:0]          estado_q, estado_d;
    logic [WIDTH-1:0]    op_a_q, op_a_d;
    logic [WIDTH-1:0]    op_b_q, op_b_d;
    logic [OP_WIDTH-1:0] opcode_q, opcode_d;
    logic [WIDTH-1:0]    resultado_q, resultado_d;
    logic [3:0]          flags_q, flags_d;
    logic                alu_valido_q, alu_valido_d;
    logic                pronto_q, pronto_d;
    logic                s1_q, s2_q, s3_q;
    logic                conf;

    // s1/s2 resynchronise the raw button; s3 remembers the previous level for edge detection.
    assign conf = s2_q & ~s3_q;

    always_comb begin
        estado_d    = estado_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        opcode_d    = opcode_q;
        resultado_d = resultado_q;
        flags_d     = flags_q;
        case (estado_q)
            CARGA_A: begin
                if (conf) begin
                    op_a_d   = sw_dado;
                    estado_d = CARGA_B;
                end
            end
            CARGA_B: begin
                if (conf) begin
                    op_b_d   = sw_dado;
                    estado_d = CARGA_OP;
                end
            end
            CARGA_OP: begin
                if (conf) begin
                    opcode_d = sw_dado[OP_WIDTH-1:0];
                    estado_d = EXECUTA;
                end
            end
            // Single-cycle execute: any confirm pulse seen here is deliberately discarded.
            EXECUTA: begin
                resultado_d = alu_resultado;
                flags_d     = alu_flags;
                estado_d    = EXIBE;
            end
            EXIBE: begin
                if (conf) begin
                    estado_d = CARGA_A;
                end
            end
            default: begin
                estado_d = CARGA_A;
            end
        endcase
        alu_valido_d = (estado_d == EXECUTA);
        pronto_d     = (estado_d == EXIBE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            estado_q     <= CARGA_A;
            op_a_q       <= '0;
            op_b_q       <= '0;
            opcode_q     <= '0;
            resultado_q  <= '0;
            flags_q      <= '0;
            alu_valido_q <= 1'b0;
            pronto_q     <= 1'b0;
            s1_q         <= 1'b0;
            s2_q         <= 1'b0;
            s3_q         <= 1'b0;
        end else begin
            estado_q     <= estado_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            opcode_q     <= opcode_d;
            resultado_q  <= resultado_d;
            flags_q      <= flags_d;
            alu_valido_q <= alu_valido_d;
            pronto_q     <= pronto_d;
            s1_q         <= btn_confirma;
            s2_q         <= s1_q;
            s3_q         <= s2_q;
        end
    end

    assign op_a          = op_a_q;
    assign op_b          = op_b_q;
    assign opcode        = opcode_q;
    assign alu_valido    = alu_valido_q;
    assign resultado_reg = resultado_q;
    assign flags_reg     = flags_q;
    assign estado        = estado_q;
    assign pronto        = pronto_q;

endmodule

// File: tb/tb_sequenciador_operandos_ula.sv
// Directed bench for sequenciador_operandos_ula with a small behavioural ULA (add, sub, xor).
module tb_sequenciador_operandos_ula;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] sw_dado = 8'h00;
    logic       btn_confirma = 1'b0;
    logic [7:0] alu_resultado;
    logic [3:0] alu_flags;
    logic [7:0] op_a, op_b, resultado_reg;
    logic [2:0] opcode, estado;
    logic [3:0] flags_reg;
    logic       alu_valido, pronto;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sequenciador_operandos_ula #(.WIDTH(8), .OP_WIDTH(3)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .sw_dado       (sw_dado),
        .btn_confirma  (btn_confirma),
        .alu_resultado (alu_resultado),
        .alu_flags     (alu_flags),
        .op_a          (op_a),
        .op_b          (op_b),
        .opcode        (opcode),
        .alu_valido    (alu_valido),
        .resultado_reg (resultado_reg),
        .flags_reg     (flags_reg),
        .estado        (estado),
        .pronto        (pronto)
    );

    // ULA model: flags are {Z,N,C,V}; for sub, C means borrow.
    logic [8:0] soma;
    logic [7:0] r;
    logic       c, v;
    always_comb begin
        soma = 9'd0;
        r    = 8'h00;
        c    = 1'b0;
        v    = 1'b0;
        case (opcode)
            3'b000: begin
                soma = {1'b0, op_a} + {1'b0, op_b};
                r    = soma[7:0];
                c    = soma[8];
                v    = (op_a[7] == op_b[7]) && (r[7] != op_a[7]);
            end
            3'b001: begin
                r = op_a - op_b;
                c = (op_a < op_b);
                v = (op_a[7] != op_b[7]) && (r[7] != op_a[7]);
            end
            default: begin
                r = op_a ^ op_b;
            end
        endcase
        alu_resultado = r;
        alu_flags     = {(r == 8'h00), r[7], c, v};
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic press(input logic [7:0] v_sw);
        @(negedge clk);
        sw_dado      = v_sw;
        btn_confirma = 1'b1;
        repeat (3) @(negedge clk);
        btn_confirma = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    // Confirms the opcode, then checks the one-cycle EXECUTA window and arrival in EXIBE.
    task automatic run_op(input logic [7:0] v_sw);
        bit seen;
        seen = 1'b0;
        @(negedge clk);
        sw_dado      = v_sw;
        btn_confirma = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (estado == 3'd3) begin
                seen = 1'b1;
                break;
            end
        end
        chk("reach_executa", {31'd0, seen}, 32'd1);
        chk("alu_valido_hi", {31'd0, alu_valido}, 32'd1);
        @(posedge clk);
        #1;
        chk("alu_valido_lo", {31'd0, alu_valido}, 32'd0);
        chk("estado_exibe", {29'd0, estado}, 32'd4);
        chk("pronto_hi", {31'd0, pronto}, 32'd1);
        @(negedge clk);
        btn_confirma = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        #1;
        chk("rst_op_a", {24'd0, op_a}, 32'h00);
        chk("rst_op_b", {24'd0, op_b}, 32'h00);
        chk("rst_opcode", {29'd0, opcode}, 32'd0);
        chk("rst_res", {24'd0, resultado_reg}, 32'h00);
        chk("rst_flags", {28'd0, flags_reg}, 32'd0);
        chk("rst_estado", {29'd0, estado}, 32'd0);
        chk("rst_pronto", {31'd0, pronto}, 32'd0);
        chk("rst_valido", {31'd0, alu_valido}, 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Latency and hold: first sample at edge N, write at N+2, then no further advance.
        sw_dado      = 8'hAA;
        btn_confirma = 1'b1;
        @(posedge clk); #1;
        chk("lat_n_estado", {29'd0, estado}, 32'd0);
        chk("lat_n_op_a", {24'd0, op_a}, 32'h00);
        @(posedge clk); #1;
        chk("lat_n1_estado", {29'd0, estado}, 32'd0);
        @(posedge clk); #1;
        chk("lat_n2_op_a", {24'd0, op_a}, 32'hAA);
        chk("lat_n2_estado", {29'd0, estado}, 32'd1);
        repeat (17) @(posedge clk);
        #1;
        chk("hold_estado", {29'd0, estado}, 32'd1);
        @(negedge clk);
        btn_confirma = 1'b0;
        repeat (3) @(negedge clk);
        press(8'h05);
        chk("repress_estado", {29'd0, estado}, 32'd2);
        chk("repress_op_b", {24'd0, op_b}, 32'h05);
        run_op(8'h00);
        chk("add_af_res", {24'd0, resultado_reg}, 32'hAF);
        chk("add_af_flags", {28'd0, flags_reg}, 32'b0100);
        press(8'h77);
        chk("exibe_exit", {29'd0, estado}, 32'd0);

        // Subtraction flags: zero, then negative with borrow.
        press(8'h05);
        press(8'h05);
        run_op(8'h01);
        chk("sub_zero_res", {24'd0, resultado_reg}, 32'h00);
        chk("sub_zero_flags", {28'd0, flags_reg}, 32'b1000);
        press(8'h00);
        press(8'h00);
        press(8'h01);
        run_op(8'h01);
        chk("sub_neg_res", {24'd0, resultado_reg}, 32'hFF);
        chk("sub_neg_flags", {28'd0, flags_reg}, 32'b0110);
        press(8'h00);

        // Opcode masking, then leaving EXIBE keeps operands and result.
        press(8'h11);
        press(8'h22);
        run_op(8'hFD);
        chk("mask_opcode", {29'd0, opcode}, 32'd5);
        chk("xor_res", {24'd0, resultado_reg}, 32'h33);
        chk("xor_flags", {28'd0, flags_reg}, 32'b0000);
        press(8'h99);
        chk("exit_estado", {29'd0, estado}, 32'd0);
        chk("exit_op_a", {24'd0, op_a}, 32'h11);
        chk("exit_op_b", {24'd0, op_b}, 32'h22);
        chk("exit_opcode", {29'd0, opcode}, 32'd5);
        chk("exit_res", {24'd0, resultado_reg}, 32'h33);
        chk("exit_pronto", {31'd0, pronto}, 32'd0);

        // Asynchronous reset in the middle of CARGA_OP.
        press(8'h3C);
        press(8'h01);
        chk("pre_rst_estado", {29'd0, estado}, 32'd2);
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_op_a", {24'd0, op_a}, 32'h00);
        chk("arst_op_b", {24'd0, op_b}, 32'h00);
        chk("arst_estado", {29'd0, estado}, 32'd0);
        chk("arst_res", {24'd0, resultado_reg}, 32'h00);
        chk("arst_pronto", {31'd0, pronto}, 32'd0);
        chk("arst_valido", {31'd0, alu_valido}, 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("post_rst_estado", {29'd0, estado}, 32'd0);
        chk("post_rst_op_a", {24'd0, op_a}, 32'h00);

        // Reference sequence: 0x3C + 0x05.
        press(8'h3C);
        press(8'h05);
        run_op(8'h00);
        chk("add_res", {24'd0, resultado_reg}, 32'h41);
        chk("add_flags", {28'd0, flags_reg}, 32'b0000);

        // Illegal state code returns to CARGA_A without touching the data registers.
        @(negedge clk);
        force dut.estado_q = 3'd6;
        #1;
        chk("ill_forced", {29'd0, estado}, 32'd6);
        release dut.estado_q;
        @(posedge clk); #1;
        chk("ill_estado", {29'd0, estado}, 32'd0);
        chk("ill_op_a", {24'd0, op_a}, 32'h3C);
        chk("ill_op_b", {24'd0, op_b}, 32'h05);
        chk("ill_opcode", {29'd0, opcode}, 32'd0);
        chk("ill_res", {24'd0, resultado_reg}, 32'h41);
        chk("ill_flags", {28'd0, flags_reg}, 32'b0000);
        chk("ill_pronto", {31'd0, pronto}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sequenciador_operandos_ula.md
Name: sequenciador_operandos_ula

Overview:
Input-capture and sequencing stage that sits directly upstream of the 8-bit ULA. It collects operand A, operand B and the opcode from a shared switch bus, one confirm press each. It then presents them to the combinational ULA for exactly one cycle and latches the ULA result and flags into output registers. All state is held in edge-triggered flip-flops with asynchronous active-low reset.

Parameters:
WIDTH, 8, data width of operands, switch bus and result
OP_WIDTH, 3, opcode width; taken from sw_dado[OP_WIDTH-1:0]

Ports:
clk  input  1  system clock, rising-edge
reset_n  input  1  asynchronous reset, active low
sw_dado  input  WIDTH  switch bus; value to capture on confirm
btn_confirma  input  1  raw push-button, active high, asynchronous to clk
alu_resultado  input  WIDTH  combinational ULA result for current op_a/op_b/opcode
alu_flags  input  4  combinational ULA flags {Z,N,C,V}
op_a  output  WIDTH  operand A register to ULA
op_b  output  WIDTH  operand B register to ULA
opcode  output  OP_WIDTH  opcode register to ULA
alu_valido  output  1  high for exactly the one cycle in EXECUTA
resultado_reg  output  WIDTH  latched ULA result
flags_reg  output  4  latched ULA flags
estado  output  3  current FSM state encoding
pronto  output  1  high while in EXIBE (result valid for display)

Behaviour:
- Reset (reset_n low, asynchronous, any time): op_a, op_b, opcode, resultado_reg, flags_reg = 0; state = CARGA_A; synchronizer/edge flops = 0; alu_valido = 0; pronto = 0. Reset takes effect immediately and is held while low; the first action is possible after release.
- Button conditioning: 2-flop synchronizer s1 -> s2, plus a history flop s3; conf = s2 & ~s3 (one-cycle pulse per press).
- Latency: btn_confirma first sampled high at edge N produces conf during cycle N+2 (after s2 rises at edge N+1, s3 still 0). The FSM acts at edge N+2.
- Holding the button produces one conf only. A new press requires btn_confirma to be sampled low at least once.
- States (estado): CARGA_A=3'd0, CARGA_B=3'd1, CARGA_OP=3'd2, EXECUTA=3'd3, EXIBE=3'd4. Codes 5-7 are illegal and return to CARGA_A on the next edge with no register writes.
- CARGA_A: on conf, op_a <= sw_dado, go to CARGA_B; otherwise hold.
- CARGA_B: on conf, op_b <= sw_dado, go to CARGA_OP.
- CARGA_OP: on conf, opcode <= sw_dado[OP_WIDTH-1:0], go to EXECUTA.
- EXECUTA: lasts exactly one cycle, unconditional. alu_valido = 1 (Moore, decoded from the state register). At the exiting edge, resultado_reg <= alu_resultado, flags_reg <= alu_flags, go to EXIBE.
- EXIBE: pronto = 1; resultado_reg and flags_reg are stable. On conf, go to CARGA_A. op_a, op_b and opcode keep their values until overwritten.
- A conf pulse occurring while in EXECUTA is dropped and not queued.
- Register writes are limited to the above. No output changes except at the listed edges or on reset.
- Width rules: no arithmetic in this block. sw_dado upper bits are ignored when loading opcode.
- The ULA is combinational. op_a, op_b and opcode are stable for at least one full cycle before EXECUTA samples the ULA outputs.

Test Plan:
- Reset: drive reset_n low mid-CARGA_OP with op_a=0x3C loaded -> immediately op_a=0, state=0, pronto=0, alu_valido=0; after release, no action until a fresh press.
- Full sequence (bench ULA model: op 3'b000 = add): press with sw=0x3C, 0x05, 0x00 -> alu_valido high for 1 cycle; then resultado_reg=0x41, flags_reg=4'b0000, pronto=1, estado=4.
- Flags capture (op 3'b001 = sub): A=0x05, B=0x05 -> resultado_reg=0x00, Z=1; next run A=0x00, B=0x01 -> resultado_reg=0xFF, N=1.
- Latency and hold: btn_confirma high at edge N and held 20 cycles with sw=0xAA -> op_a=0xAA written at edge N+2, state=1, no further advance; release then re-press -> advance to CARGA_OP.
- Opcode masking: sw=0xFD in CARGA_OP -> opcode=3'b101. Press in EXIBE -> state=0, op_a/op_b/opcode unchanged, resultado_reg held.
- Illegal state: force estado=3'd6 -> next edge estado=0, no register changes.
